// File: rtl/cache_l2_pkg.sv
// Shared types and sizes for the 8-line fully associative L2 cache.
package cache_l2_pkg;
  localparam int DATA_W = 17;
  localparam int ADDR_W = 7;
  localparam int LINES  = 8;
  localparam int TAG_W  = ADDR_W - 1;
  localparam int AGE_W  = $clog2(LINES);

  typedef logic [AGE_W-1:0] idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MEM_WR,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_RESP
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] word0;
    logic [DATA_W-1:0] word1;
    logic [AGE_W-1:0]  age;
  } line_t;
endpackage

// File: rtl/cache_l2_fa_lru.sv
// True-LRU age registers for the L2 lines, plus victim selection.
module l2_lru_age
  import cache_l2_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             upd_en,
  input  idx_t             upd_idx,
  input  logic [AGE_W-1:0] upd_age,
  input  logic [LINES-1:0] valid_i,
  output logic [AGE_W-1:0] age_o [LINES],
  output idx_t             victim_o
);
  logic [AGE_W-1:0] age_q [LINES];
  logic [AGE_W-1:0] age_d [LINES];
  logic             free_found;

  // Ages younger than the touched line shift up by one, keeping a permutation.
  always_comb begin
    for (int i = 0; i < LINES; i++) begin
      age_d[i] = age_q[i];
      if (upd_en) begin
        if (idx_t'(i) == upd_idx) begin
          age_d[i] = '0;
        end else if (age_q[i] < upd_age) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    victim_o   = '0;
    free_found = 1'b0;
    for (int i = 0; i < LINES; i++) begin
      if (!free_found && !valid_i[i]) begin
        victim_o   = idx_t'(i);
        free_found = 1'b1;
      end
    end
    if (!free_found) begin
      for (int i = 0; i < LINES; i++) begin
        if (age_q[i] == '1) victim_o = idx_t'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) age_q[i] <= AGE_W'(i);
    end else begin
      age_q <= age_d;
    end
  end

  assign age_o = age_q;
endmodule

// File: rtl/cache_l2_fa.sv
// Fully associative write-through L2: one request at a time, 2-word line fill on read miss.
module cache_l2_fa
  import cache_l2_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wren,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_q,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_e            state_q, state_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              beat_q, beat_d;
  idx_t              victim_q, victim_d;
  logic              hit_q, hit_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [TAG_W-1:0]  tag_d [LINES];
  logic [DATA_W-1:0] word_q [LINES][2];
  logic [DATA_W-1:0] word_d [LINES][2];

  line_t             line_v [LINES];
  logic [AGE_W-1:0]  age [LINES];
  logic [LINES-1:0]  match;
  logic              lookup_hit;
  idx_t              hit_idx;
  idx_t              victim;
  logic              upd_en;
  idx_t              upd_idx;
  logic [AGE_W-1:0]  upd_age;
  logic [TAG_W-1:0]  req_tag;
  logic              req_off;

  assign req_tag = addr_q[ADDR_W-1:1];
  assign req_off = addr_q[0];

  l2_lru_age u_lru (
    .clk      (clk),
    .reset    (reset),
    .upd_en   (upd_en),
    .upd_idx  (upd_idx),
    .upd_age  (upd_age),
    .valid_i  (valid_q),
    .age_o    (age),
    .victim_o (victim)
  );

  // Tag compare across all lines; valid tags are unique so at most one matches.
  always_comb begin
    match   = '0;
    hit_idx = '0;
    for (int i = 0; i < LINES; i++) begin
      line_v[i].valid = valid_q[i];
      line_v[i].tag   = tag_q[i];
      line_v[i].word0 = word_q[i][0];
      line_v[i].word1 = word_q[i][1];
      line_v[i].age   = age[i];
      match[i]        = line_v[i].valid && (line_v[i].tag == req_tag);
      if (match[i]) hit_idx = idx_t'(i);
    end
  end

  assign lookup_hit = |match;
  assign upd_age    = line_v[upd_idx].age;

  always_comb begin
    state_d  = state_q;
    wren_d   = wren_q;
    addr_d   = addr_q;
    data_d   = data_q;
    beat_d   = beat_q;
    victim_d = victim_q;
    hit_d    = hit_q;
    rdata_d  = rdata_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    word_d   = word_q;
    upd_en   = 1'b0;
    upd_idx  = hit_idx;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wren_d  = req_wren;
          addr_d  = req_addr;
          data_d  = req_data;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_d = lookup_hit;
        if (wren_q) begin
          if (lookup_hit) begin
            word_d[hit_idx][req_off] = data_q;
            upd_en = 1'b1;
          end
          state_d = S_MEM_WR;
        end else if (lookup_hit) begin
          rdata_d = req_off ? line_v[hit_idx].word1 : line_v[hit_idx].word0;
          upd_en  = 1'b1;
          state_d = S_RESP;
        end else begin
          // Drop the victim's valid now so an aborted fill never leaves a mixed line.
          victim_d        = victim;
          valid_d[victim] = 1'b0;
          beat_d          = 1'b0;
          state_d         = S_FILL_REQ;
        end
      end
      S_MEM_WR: begin
        if (mem_req_ready) begin
          rdata_d = data_q;
          state_d = S_RESP;
        end
      end
      S_FILL_REQ: begin
        if (mem_req_ready) state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (mem_rvalid) begin
          word_d[victim_q][beat_q] = mem_rdata;
          if (req_off == beat_q) rdata_d = mem_rdata;
          if (!beat_q) begin
            beat_d  = 1'b1;
            state_d = S_FILL_REQ;
          end else begin
            tag_d[victim_q]   = req_tag;
            valid_d[victim_q] = 1'b1;
            upd_en            = 1'b1;
            upd_idx           = victim_q;
            state_d           = S_RESP;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      beat_q   <= 1'b0;
      victim_q <= '0;
      hit_q    <= 1'b0;
      rdata_q  <= '0;
      valid_q  <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]     <= '0;
        word_q[i][0] <= '0;
        word_q[i][1] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      beat_q   <= beat_d;
      victim_q <= victim_d;
      hit_q    <= hit_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      word_q   <= word_d;
    end
  end

  // Outputs decode straight from registered state, so they hold steady through a stall.
  assign req_ready     = (state_q == S_IDLE);
  assign resp_valid    = (state_q == S_RESP);
  assign resp_hit      = hit_q;
  assign resp_q        = rdata_q;
  assign mem_req_valid = (state_q == S_MEM_WR) || (state_q == S_FILL_REQ);
  assign mem_wren      = (state_q == S_MEM_WR);
  assign mem_addr      = (state_q == S_MEM_WR)   ? addr_q :
                         (state_q == S_FILL_REQ) ? {req_tag, beat_q} : '0;
  assign mem_wdata     = (state_q == S_MEM_WR) ? data_q : '0;
endmodule

// File: tb/tb_cache_l2_fa.sv
// Directed bench for cache_l2_fa with a small latency-configurable memory model.
module tb_cache_l2_fa;
  import cache_l2_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_wren;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              resp_valid;
  logic              resp_hit;
  logic [DATA_W-1:0] resp_q;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] mem_arr [128];
  int                rd_lat = 1;
  logic [ADDR_W-1:0] rd_log [$];
  logic [ADDR_W-1:0] wr_addr_log [$];
  logic [DATA_W-1:0] wr_data_log [$];
  bit                pend;
  int                pcnt;
  logic [DATA_W-1:0] pdata;

  always #5 clk = ~clk;

  cache_l2_fa dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wren      (req_wren),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .resp_valid    (resp_valid),
    .resp_hit      (resp_hit),
    .resp_q        (resp_q),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_wren      (mem_wren),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  // Memory model: sees the handshake on the negedge before the accepting posedge.
  initial begin
    pend       = 1'b0;
    pcnt       = 0;
    pdata      = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (pend) begin
        pcnt--;
        if (pcnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pdata;
          pend       = 1'b0;
        end
      end
      if (!reset && mem_req_valid && mem_req_ready) begin
        if (mem_wren) begin
          wr_addr_log.push_back(mem_addr);
          wr_data_log.push_back(mem_wdata);
          mem_arr[mem_addr] = mem_wdata;
        end else begin
          rd_log.push_back(mem_addr);
          pdata = mem_arr[mem_addr];
          pcnt  = rd_lat;
          pend  = 1'b1;
        end
      end
    end
  end

  task automatic do_req(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        output logic hit, output logic [DATA_W-1:0] q, output int lat,
                        output logic to, output logic pulse);
    req_valid = 1'b1;
    req_wren  = wr;
    req_addr  = a;
    req_data  = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    to  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (resp_valid === 1'b1) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    hit = resp_hit;
    q   = resp_q;
    @(posedge clk); #1;
    pulse = (resp_valid === 1'b0) && (req_ready === 1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_checks++; if (resp_hit !== 1'b0) $display("FAIL rst_resp_hit: got %b want 0", resp_hit); else n_pass++;
    n_checks++; if (resp_q !== '0) $display("FAIL rst_resp_q: got %h want 0", resp_q); else n_pass++;
    n_checks++; if (mem_req_valid !== 1'b0) $display("FAIL rst_mem_req_valid: got %b want 0", mem_req_valid); else n_pass++;
    n_checks++; if (mem_wren !== 1'b0) $display("FAIL rst_mem_wren: got %b want 0", mem_wren); else n_pass++;
    n_checks++; if (mem_addr !== '0) $display("FAIL rst_mem_addr: got %h want 0", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== '0) $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_read_miss_fill;
    logic hit, to, pulse;
    logic [DATA_W-1:0] q;
    logic [ADDR_W-1:0] a0, a1;
    int lat;
    rd_log.delete();
    do_req(1'b0, 7'h05, '0, hit, q, lat, to, pulse);
    a0 = (rd_log.size() > 0) ? rd_log[0] : 7'h7f;
    a1 = (rd_log.size() > 1) ? rd_log[1] : 7'h7f;
    n_checks++; if (to !== 1'b0) $display("FAIL miss_timeout: got %b want 0", to); else n_pass++;
    n_checks++; if (hit !== 1'b0) $display("FAIL miss_hit: got %b want 0", hit); else n_pass++;
    n_checks++; if (q !== 17'h0BBBB) $display("FAIL miss_q: got %h want 0bbbb", q); else n_pass++;
    n_checks++; if (rd_log.size() != 2) $display("FAIL miss_nreads: got %0d want 2", rd_log.size()); else n_pass++;
    n_checks++; if (a0 !== 7'h04) $display("FAIL miss_rd0_addr: got %h want 04", a0); else n_pass++;
    n_checks++; if (a1 !== 7'h05) $display("FAIL miss_rd1_addr: got %h want 05", a1); else n_pass++;
    n_checks++; if (pulse !== 1'b1) $display("FAIL miss_pulse: got %b want 1", pulse); else n_pass++;
  endtask

  task automatic test_read_hit;
    logic hit, to, pulse;
    logic [DATA_W-1:0] q;
    int lat;
    rd_log.delete();
    do_req(1'b0, 7'h05, '0, hit, q, lat, to, pulse);
    n_checks++; if (to !== 1'b0) $display("FAIL hit_timeout: got %b want 0", to); else n_pass++;
    n_checks++; if (hit !== 1'b1) $display("FAIL hit_hit: got %b want 1", hit); else n_pass++;
    n_checks++; if (q !== 17'h0BBBB) $display("FAIL hit_q: got %h want 0bbbb", q); else n_pass++;
    n_checks++; if (lat != 2) $display("FAIL hit_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (rd_log.size() != 0) $display("FAIL hit_nreads: got %0d want 0", rd_log.size()); else n_pass++;
    n_checks++; if (pulse !== 1'b1) $display("FAIL hit_pulse: got %b want 1", pulse); else n_pass++;
  endtask

  task automatic test_write_hit;
    logic hit, to, pulse;
    logic [DATA_W-1:0] q, wd;
    logic [ADDR_W-1:0] wa;
    int lat;
    wr_addr_log.delete();
    wr_data_log.delete();
    rd_log.delete();
    do_req(1'b1, 7'h05, 17'h12345, hit, q, lat, to, pulse);
    wa = (wr_addr_log.size() > 0) ? wr_addr_log[0] : 7'h7f;
    wd = (wr_data_log.size() > 0) ? wr_data_log[0] : 17'h1FFFF;
    n_checks++; if (to !== 1'b0) $display("FAIL wrhit_timeout: got %b want 0", to); else n_pass++;
    n_checks++; if (hit !== 1'b1) $display("FAIL wrhit_hit: got %b want 1", hit); else n_pass++;
    n_checks++; if (q !== 17'h12345) $display("FAIL wrhit_q: got %h want 12345", q); else n_pass++;
    n_checks++; if (wr_addr_log.size() != 1) $display("FAIL wrhit_nwrites: got %0d want 1", wr_addr_log.size()); else n_pass++;
    n_checks++; if (wa !== 7'h05) $display("FAIL wrhit_mem_addr: got %h want 05", wa); else n_pass++;
    n_checks++; if (wd !== 17'h12345) $display("FAIL wrhit_mem_data: got %h want 12345", wd); else n_pass++;
    do_req(1'b0, 7'h05, '0, hit, q, lat, to, pulse);
    n_checks++; if (hit !== 1'b1) $display("FAIL wrhit_rd_hit: got %b want 1", hit); else n_pass++;
    n_checks++; if (q !== 17'h12345) $display("FAIL wrhit_rd_q: got %h want 12345", q); else n_pass++;
    n_checks++; if (rd_log.size() != 0) $display("FAIL wrhit_rd_nreads: got %0d want 0", rd_log.size()); else n_pass++;
  endtask

  task automatic test_write_miss;
    logic hit, to, pulse;
    logic [DATA_W-1:0] q;
    logic [ADDR_W-1:0] wa;
    int lat;
    wr_addr_log.delete();
    wr_data_log.delete();
    rd_log.delete();
    do_req(1'b1, 7'h40, 17'h00777, hit, q, lat, to, pulse);
    wa = (wr_addr_log.size() > 0) ? wr_addr_log[0] : 7'h7f;
    n_checks++; if (hit !== 1'b0) $display("FAIL wrmiss_hit: got %b want 0", hit); else n_pass++;
    n_checks++; if (wr_addr_log.size() != 1) $display("FAIL wrmiss_nwrites: got %0d want 1", wr_addr_log.size()); else n_pass++;
    n_checks++; if (wa !== 7'h40) $display("FAIL wrmiss_mem_addr: got %h want 40", wa); else n_pass++;
    do_req(1'b0, 7'h40, '0, hit, q, lat, to, pulse);
    n_checks++; if (hit !== 1'b0) $display("FAIL wrmiss_rd_hit: got %b want 0", hit); else n_pass++;
    n_checks++; if (q !== 17'h00777) $display("FAIL wrmiss_rd_q: got %h want 00777", q); else n_pass++;
    n_checks++; if (rd_log.size() != 2) $display("FAIL wrmiss_rd_nreads: got %0d want 2", rd_log.size()); else n_pass++;
  endtask

  task automatic test_lru_evict;
    logic hit, to, pulse;
    logic [DATA_W-1:0] q;
    int lat;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      do_req(1'b0, 7'(2 * k), '0, hit, q, lat, to, pulse);
      n_checks++; if (hit !== 1'b0) $display("FAIL lru_fill%0d_hit: got %b want 0", k, hit); else n_pass++;
    end
    do_req(1'b0, 7'h00, '0, hit, q, lat, to, pulse);
    n_checks++; if (hit !== 1'b1) $display("FAIL lru_reread0_hit: got %b want 1", hit); else n_pass++;
    n_checks++; if (q !== 17'h00100) $display("FAIL lru_reread0_q: got %h want 00100", q); else n_pass++;
    rd_log.delete();
    do_req(1'b0, 7'h10, '0, hit, q, lat, to, pulse);
    n_checks++; if (hit !== 1'b0) $display("FAIL lru_ninth_hit: got %b want 0", hit); else n_pass++;
    n_checks++; if (q !== 17'h00110) $display("FAIL lru_ninth_q: got %h want 00110", q); else n_pass++;
    n_checks++; if (rd_log.size() != 2) $display("FAIL lru_ninth_nreads: got %0d want 2", rd_log.size()); else n_pass++;
    do_req(1'b0, 7'h00, '0, hit, q, lat, to, pulse);
    n_checks++; if (hit !== 1'b1) $display("FAIL lru_keep0_hit: got %b want 1", hit); else n_pass++;
    do_req(1'b0, 7'h0E, '0, hit, q, lat, to, pulse);
    n_checks++; if (hit !== 1'b1) $display("FAIL lru_keep0e_hit: got %b want 1", hit); else n_pass++;
    n_checks++; if (q !== 17'h0010E) $display("FAIL lru_keep0e_q: got %h want 0010e", q); else n_pass++;
    do_req(1'b0, 7'h02, '0, hit, q, lat, to, pulse);
    n_checks++; if (hit !== 1'b0) $display("FAIL lru_evicted02_hit: got %b want 0", hit); else n_pass++;
    n_checks++; if (q !== 17'h00102) $display("FAIL lru_evicted02_q: got %h want 00102", q); else n_pass++;
  endtask

  task automatic test_stall;
    logic seen, done;
    logic [ADDR_W-1:0] a0;
    rd_log.delete();
    mem_req_ready = 1'b0;
    req_valid = 1'b1;
    req_wren  = 1'b0;
    req_addr  = 7'h20;
    req_data  = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 1'b1) $display("FAIL stall_req_seen: got %b want 1", seen); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (mem_req_valid !== 1'b1) $display("FAIL stall_valid_c%0d: got %b want 1", c, mem_req_valid); else n_pass++;
      n_checks++; if (mem_addr !== 7'h20) $display("FAIL stall_addr_c%0d: got %h want 20", c, mem_addr); else n_pass++;
      n_checks++; if (mem_wren !== 1'b0) $display("FAIL stall_wren_c%0d: got %b want 0", c, mem_wren); else n_pass++;
      n_checks++; if (req_ready !== 1'b0) $display("FAIL stall_req_ready_c%0d: got %b want 0", c, req_ready); else n_pass++;
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (resp_valid === 1'b1) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    a0 = (rd_log.size() > 0) ? rd_log[0] : 7'h7f;
    n_checks++; if (done !== 1'b1) $display("FAIL stall_resp_timeout: got %b want 1", done); else n_pass++;
    n_checks++; if (resp_q !== 17'h00120) $display("FAIL stall_q: got %h want 00120", resp_q); else n_pass++;
    n_checks++; if (rd_log.size() != 2) $display("FAIL stall_nreads: got %0d want 2", rd_log.size()); else n_pass++;
    n_checks++; if (a0 !== 7'h20) $display("FAIL stall_rd0_addr: got %h want 20", a0); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    logic hit, to, pulse, seen;
    logic [DATA_W-1:0] q;
    int lat;
    rd_lat = 4;
    req_valid = 1'b1;
    req_wren  = 1'b0;
    req_addr  = 7'h30;
    req_data  = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 1'b1) $display("FAIL abort_req_seen: got %b want 1", seen); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (mem_req_valid !== 1'b0) $display("FAIL abort_wait_valid: got %b want 0", mem_req_valid); else n_pass++;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL abort_wait_ready: got %b want 0", req_ready); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL abort_rst_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL abort_rst_resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_checks++; if (resp_q !== '0) $display("FAIL abort_rst_resp_q: got %h want 0", resp_q); else n_pass++;
    n_checks++; if (resp_hit !== 1'b0) $display("FAIL abort_rst_resp_hit: got %b want 0", resp_hit); else n_pass++;
    n_checks++; if (mem_req_valid !== 1'b0) $display("FAIL abort_rst_mem_valid: got %b want 0", mem_req_valid); else n_pass++;
    n_checks++; if (mem_addr !== '0) $display("FAIL abort_rst_mem_addr: got %h want 0", mem_addr); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL abort_stale_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL abort_stale_resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_checks++; if (mem_req_valid !== 1'b0) $display("FAIL abort_stale_mem_valid: got %b want 0", mem_req_valid); else n_pass++;
    rd_lat = 1;
    rd_log.delete();
    do_req(1'b0, 7'h30, '0, hit, q, lat, to, pulse);
    n_checks++; if (to !== 1'b0) $display("FAIL abort_reread_timeout: got %b want 0", to); else n_pass++;
    n_checks++; if (hit !== 1'b0) $display("FAIL abort_reread_hit: got %b want 0", hit); else n_pass++;
    n_checks++; if (q !== 17'h00130) $display("FAIL abort_reread_q: got %h want 00130", q); else n_pass++;
    n_checks++; if (rd_log.size() != 2) $display("FAIL abort_reread_nreads: got %0d want 2", rd_log.size()); else n_pass++;
  endtask

  initial begin
    reset         = 1'b1;
    req_valid     = 1'b0;
    req_wren      = 1'b0;
    req_addr      = '0;
    req_data      = '0;
    mem_req_ready = 1'b1;
    for (int i = 0; i < 128; i++) mem_arr[i] = 17'h00100 + 17'(i);
    mem_arr[4] = 17'h1AAAA;
    mem_arr[5] = 17'h0BBBB;

    test_reset();
    test_read_miss_fill();
    test_read_hit();
    test_write_hit();
    test_write_miss();
    test_lru_evict();
    test_stall();
    test_reset_abort();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
